// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage with IF/ID pipeline register.
//                Owns the PC, fetches over a req/rdy handshake, and presents
//                pc/instr/valid to decode. Handles load-use stalls (with a
//                one-entry skid buffer) and EX branch/jump redirects.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                imem_req/addr       - fetch request and word-aligned address
//                imem_rdy/rdata      - fetch response handshake and data
//                stall_if            - hold PC and IF/ID
//                redirect/redirect_pc- taken branch/jump target from EX
//                pc_if_out/instr_if_out/valid_if_out - IF/ID contents
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    input  logic        stall_if,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_if_out,
    output logic [31:0] instr_if_out,
    output logic        valid_if_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_valid_q, buf_valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] redirect_pc_aligned;
    logic [31:0] pc_plus4;

    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
    assign pc_plus4            = pc_q + 32'd4;   // wraps silently at 2^32

    assign imem_req     = (state_q != HOLD);
    assign imem_addr    = pc_q;
    assign pc_if_out    = ifid_pc_q;
    assign instr_if_out = ifid_instr_q;
    assign valid_if_out = ifid_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_valid_d  = buf_valid_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (redirect) begin
            // Redirect beats stall: whatever sits in ID is wrong-path.
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if (state_q == HOLD || imem_rdy) begin
                // No request left in flight: jump straight to the target.
                pc_d         = redirect_pc_aligned;
                redir_pend_d = 1'b0;
                state_d      = FETCH;
            end else begin
                // Outstanding request must complete at its own address,
                // so remember the target and drop the response later.
                redir_pend_d = 1'b1;
                redir_tgt_d  = redirect_pc_aligned;
                state_d      = WAIT;
            end
        end else begin
            case (state_q)
                FETCH, WAIT: begin
                    if (imem_rdy) begin
                        if (redir_pend_q) begin
                            pc_d         = redir_tgt_q;
                            redir_pend_d = 1'b0;
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                            state_d      = FETCH;
                        end else if (!stall_if) begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem_rdata;
                            ifid_valid_d = 1'b1;
                            pc_d         = pc_plus4;
                            state_d      = FETCH;
                        end else begin
                            // Decode is frozen: park the response.
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem_rdata;
                            buf_valid_d = 1'b1;
                            pc_d        = pc_plus4;
                            state_d     = HOLD;
                        end
                    end else begin
                        state_d = WAIT;
                        if (!stall_if) begin
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_if) begin
                        ifid_pc_d    = buf_pc_q;
                        ifid_instr_d = buf_instr_q;
                        ifid_valid_d = 1'b1;
                        buf_valid_d  = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            buf_pc_q     <= 32'd0;
            buf_instr_q  <= NOP_INSTR;
            buf_valid_q  <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_valid_q  <= buf_valid_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for if_stage. Instruction
//                memory is a pc-indexed ROM (data = 0xA000_0000 | addr).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
    localparam logic [31:0] C_TAG = 32'hA000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic        stall_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_if_out;
    logic [31:0] instr_if_out;
    logic        valid_if_out;

    int n_vec  = 0;
    int n_miss = 0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_rdata   (imem_rdata),
        .stall_if     (stall_if),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc_if_out    (pc_if_out),
        .instr_if_out (instr_if_out),
        .valid_if_out (valid_if_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: instruction word encodes its own address.
    always_comb imem_rdata = C_TAG | imem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check IF/ID triple; instr expected is derived from pc for valid entries.
    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, valid_if_out}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, pc_if_out, pc);
            chk({tag, "_instr"}, instr_if_out, C_TAG | pc);
        end else begin
            chk({tag, "_instr"}, instr_if_out, C_NOP);
        end
    endtask

    initial begin
        rst = 1'b1; imem_rdy = 1'b1; stall_if = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, valid_if_out}, 32'd0);
        chk("rst_instr", instr_if_out, C_NOP);
        chk("rst_pc",    pc_if_out, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd1);
        chk("rst_addr",  imem_addr, 32'd0);

        // 1: zero-wait streaming
        tick(); chk_ifid("t1_0", 1'b1, 32'h0); chk("t1_addr", imem_addr, 32'h4);
        tick(); chk_ifid("t1_4", 1'b1, 32'h4); chk("t1_addr8", imem_addr, 32'h8);

        // 2: rdy low three cycles at 0x8
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("t2_bubble", 1'b0, 32'h0);
            chk("t2_addr", imem_addr, 32'h8);
            chk("t2_req", {31'd0, imem_req}, 32'd1);
        end
        imem_rdy = 1'b1;
        tick(); chk_ifid("t2_8", 1'b1, 32'h8);
        tick(); chk_ifid("t2_c", 1'b1, 32'hC);

        // 3: stall two cycles, 0x10 buffered
        stall_if = 1'b1;
        tick(); chk_ifid("t3_frz1", 1'b1, 32'hC); chk("t3_req1", {31'd0, imem_req}, 32'd0);
        tick(); chk_ifid("t3_frz2", 1'b1, 32'hC); chk("t3_req2", {31'd0, imem_req}, 32'd0);
        chk("t3_addr", imem_addr, 32'h14);
        stall_if = 1'b0;
        tick(); chk_ifid("t3_10", 1'b1, 32'h10); chk("t3_req3", {31'd0, imem_req}, 32'd1);
        tick(); chk_ifid("t3_14", 1'b1, 32'h14);

        // 4: redirect with stall, unaligned target
        stall_if = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        tick(); chk_ifid("t4_bub", 1'b0, 32'h0); chk("t4_addr", imem_addr, 32'h100);
        stall_if = 1'b0; redirect = 1'b0;
        tick(); chk_ifid("t4_100", 1'b1, 32'h100);

        // 5: redirect during WAIT at 0x20 to 0x40
        redirect = 1'b1; redirect_pc = 32'h20;
        tick(); chk("t5_addr20", imem_addr, 32'h20);
        redirect = 1'b0; imem_rdy = 1'b0;
        tick(); chk_ifid("t5_wait", 1'b0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick(); chk_ifid("t5_pend", 1'b0, 32'h0); chk("t5_hold1", imem_addr, 32'h20);
        redirect = 1'b0;
        tick(); chk_ifid("t5_pend2", 1'b0, 32'h0); chk("t5_hold2", imem_addr, 32'h20);
        imem_rdy = 1'b1;
        tick(); chk_ifid("t5_drop", 1'b0, 32'h0); chk("t5_addr40", imem_addr, 32'h40);
        tick(); chk_ifid("t5_40", 1'b1, 32'h40);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick(); chk_ifid("wr_top", 1'b1, 32'hFFFF_FFFC); chk("wr_addr0", imem_addr, 32'h0);
        tick(); chk_ifid("wr_0", 1'b1, 32'h0);

        // 6a: reset while in HOLD
        stall_if = 1'b1;
        tick(); chk("t6_hold_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1; stall_if = 1'b0;
        tick();
        chk_ifid("t6a_rst", 1'b0, 32'h0);
        chk("t6a_pc", pc_if_out, 32'd0);
        chk("t6a_addr", imem_addr, 32'd0);
        chk("t6a_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b0;
        tick(); chk_ifid("t6a_0", 1'b1, 32'h0);

        // 6b: reset while in WAIT, late rdy taken as RESET_PC response
        imem_rdy = 1'b0;
        tick(); chk("t6b_addr4", imem_addr, 32'h4);
        rst = 1'b1;
        tick();
        chk_ifid("t6b_rst", 1'b0, 32'h0);
        chk("t6b_addr", imem_addr, 32'd0);
        rst = 1'b0; imem_rdy = 1'b1;
        tick(); chk_ifid("t6b_0", 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
